// File: rtl/rom_arb_pkg.sv
// Shared constants, FSM state type and the two-way round-robin pick
// function for the ROM stream arbiter.
package rom_arb_pkg;

   // Default geometry of the ROM and the burst-length field.
   localparam int DEPTH  = 896;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   // IDLE accepts a request; BURST streams beats out of the ROM.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Grant for two requesters. A lone requester always wins; under
   // contention the pointer names the requester that has priority.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                          input logic       ptr);
      logic [1:0] grant;
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      return grant;
   endfunction

endpackage

// File: rtl/rom_arb_rr2.sv
// Two-way round-robin grant. The pointer flop lives here and moves only
// when the parent reports that the current grant was taken (advance).
module rom_arb_rr2
   import rom_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic r_ptr;

   // Combinational grant from the current pointer.
   always_comb begin
      grant = rr_pick(valid, r_ptr);
   end

   // After a taken grant, priority passes to the requester that lost:
   // winner 0 -> pointer 1, winner 1 -> pointer 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (advance) begin
         r_ptr <= grant[0];
      end
   end

endmodule

// File: rtl/rom_stream_arbiter.sv
// ROM stream arbiter: two requesters compete for bursts read out of a
// combinational ROM. Each accepted request streams len+1 beats through a
// one-entry output register; a start address past the ROM end yields a
// single error beat instead.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high on that channel (req_valid[i]/req_ready[i], and
// rsp_valid/rsp_ready). rsp_* outputs hold steady while rsp_valid is
// high and rsp_ready is low.
module rom_stream_arbiter #(
   parameter int DEPTH  = rom_arb_pkg::DEPTH,
   parameter int ADDR_W = rom_arb_pkg::ADDR_W,
   parameter int DATA_W = rom_arb_pkg::DATA_W,
   parameter int LEN_W  = rom_arb_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [LEN_W-1:0]  req_len0,
   input  logic [LEN_W-1:0]  req_len1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              busy
);

   import rom_arb_pkg::*;

   // DEPTH may equal 2**ADDR_W, so the range compare uses one extra bit.
   localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH - 1);

   // FSM state
   arb_state_e r_state;
   arb_state_e w_state_nxt;

   // Arbitration / request side
   logic [1:0]        w_arb_valid;
   logic [1:0]        w_grant;
   logic              w_hs;
   logic              w_hs_id;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [LEN_W-1:0]  w_sel_len;
   logic              w_sel_oor;

   // Burst context
   logic [ADDR_W-1:0] r_beat_addr;
   logic [LEN_W-1:0]  r_remain;
   logic              r_id;
   logic              r_oor;
   logic [ADDR_W-1:0] w_addr_inc;

   // Output register
   logic              w_load;
   logic              w_load_last;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_id;
   logic              r_rsp_last;
   logic              r_rsp_err;

   // Requests are only offered to the arbiter while idle, so the grant
   // is naturally zero during a burst.
   always_comb begin
      w_arb_valid = (r_state == ST_IDLE) ? req_valid : 2'b00;
   end

   rom_arb_rr2 u_rr2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (w_arb_valid),
      .advance (w_hs),
      .grant   (w_grant)
   );

   // Request-side decode: ready is forced low while reset is asserted,
   // and the winning requester's address/length are selected.
   always_comb begin
      req_ready  = rst_n ? w_grant : 2'b00;
      w_hs       = |(req_valid & req_ready);
      w_hs_id    = req_ready[1];
      w_sel_addr = w_hs_id ? req_addr1 : req_addr0;
      w_sel_len  = w_hs_id ? req_len1  : req_len0;
      w_sel_oor  = ({1'b0, w_sel_addr} >= LP_DEPTH);
   end

   // Beat scheduling: the output register takes a new beat whenever the
   // burst is active and the register is empty or being drained.
   always_comb begin
      w_load      = (r_state == ST_BURST) && (!r_rsp_valid || rsp_ready);
      w_load_last = r_oor || (r_remain == '0);
      w_addr_inc  = (r_beat_addr == LP_LAST_ADDR) ? '0 : r_beat_addr + 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; busy mirrors the BURST state.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_hs) begin
               w_state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            busy = 1'b1;
            if (w_load && w_load_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Burst context: captured on the handshake, advanced on every load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_addr <= '0;
         r_remain    <= '0;
         r_id        <= 1'b0;
         r_oor       <= 1'b0;
      end else if (w_hs) begin
         r_beat_addr <= w_sel_addr;
         r_remain    <= w_sel_len;
         r_id        <= w_hs_id;
         r_oor       <= w_sel_oor;
      end else if (w_load) begin
         r_beat_addr <= w_addr_inc;
         r_remain    <= r_remain - 1'b1;
      end
   end

   // One-entry output register. An out-of-range burst collapses to one
   // zero-data error beat and the ROM word is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else if (w_load) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= r_oor ? '0 : rom_data;
         r_rsp_id    <= r_id;
         r_rsp_last  <= w_load_last;
         r_rsp_err   <= r_oor;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Output wiring.
   always_comb begin
      rom_addr  = r_beat_addr;
      rsp_valid = r_rsp_valid;
      rsp_data  = r_rsp_data;
      rsp_id    = r_rsp_id;
      rsp_last  = r_rsp_last;
      rsp_err   = r_rsp_err;
   end

endmodule

// File: tb/tb_rom_stream_arbiter.sv
// Testbench for rom_stream_arbiter: directed scenarios followed by a
// randomized two-requester run, with a reference model that turns every
// accepted request into its expected beat list.
module tb_rom_stream_arbiter;

   localparam int M_DEPTH = 896;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_addr0, req_addr1;
   logic [3:0]  req_len0, req_len1;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic        rsp_last;
   logic        rsp_err;
   logic        busy;

   logic        v0, v1;
   int          cyc;
   int          n_total;
   int          n_pass;

   // Scoreboard: {id, last, err, data}
   logic [10:0] exp_q[$];

   // Monitor/model state
   logic        m_ptr;
   logic        p_valid, p_ready;
   logic [11:0] p_snap;
   logic        busy_chk;
   logic        first_pending;
   logic        lat_chk;
   int          hs_cyc;
   int          prev_beat_cyc;
   int          n_beats;
   logic        rand_on;

   assign req_valid = {v1, v0};

   rom_stream_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr0 (req_addr0),
      .req_addr1 (req_addr1),
      .req_len0  (req_len0),
      .req_len1  (req_len1),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_last  (rsp_last),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   // ---------------- ROM contents ----------------
   function automatic logic [7:0] rom_fn(input logic [9:0] a);
      logic [15:0] t;
      t = {6'd0, a} * 16'd37 + {9'd0, a[9:3]};
      return t[7:0] ^ 8'h5A;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] model_pick(input logic [1:0] v, input logic ptr);
      if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
      return v;
   endfunction

   task automatic push_burst(input logic id, input logic [9:0] a, input logic [3:0] l);
      int ad;
      if (int'(a) >= M_DEPTH) begin
         exp_q.push_back({id, 1'b1, 1'b1, 8'h00});
      end else begin
         for (int k = 0; k <= int'(l); k++) begin
            ad = (int'(a) + k) % M_DEPTH;
            exp_q.push_back({id, (k == int'(l)), 1'b0, rom_fn(10'(ad))});
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [1:0]  exp_rdy;
      logic [10:0] e;
      logic        nb;
      logic        hid;
      if (!rst_n) begin
         m_ptr         = 1'b0;
         p_valid       = 1'b0;
         p_ready       = 1'b0;
         busy_chk      = 1'b0;
         first_pending = 1'b0;
      end else begin
         if (busy_chk) begin
            chk("busy_after_handshake", 32'(busy), 32'd1);
            busy_chk = 1'b0;
         end
         // held beat must not change
         if (p_valid && !p_ready)
            chk("hold_stable", 32'({rsp_valid, rsp_id, rsp_last, rsp_err, rsp_data}), 32'(p_snap));
         nb = rsp_valid && (!p_valid || p_ready);
         if (nb) begin
            n_beats++;
            chk("busy_vs_last", 32'(busy), 32'(!rsp_last));
            if (lat_chk) begin
               if (first_pending) chk("first_beat_latency", 32'(cyc - hs_cyc), 32'd2);
               else               chk("beat_spacing", 32'(cyc - prev_beat_cyc), 32'd1);
            end
            first_pending = 1'b0;
            prev_beat_cyc = cyc;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_beat: got 0x%0h expected none (cycle %0d)",
                        {rsp_id, rsp_last, rsp_err, rsp_data}, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("beat {id,last,err,data}", 32'({rsp_id, rsp_last, rsp_err, rsp_data}), 32'(e));
            end
         end
         // arbitration
         exp_rdy = busy ? 2'b00 : model_pick(req_valid, m_ptr);
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if ((req_valid & req_ready) != 2'b00) begin
            hid = req_ready[1];
            push_burst(hid, hid ? req_addr1 : req_addr0, hid ? req_len1 : req_len0);
            m_ptr         = !hid;
            hs_cyc        = cyc;
            first_pending = 1'b1;
            busy_chk      = 1'b1;
         end
         p_valid = rsp_valid;
         p_ready = rsp_ready;
         p_snap  = {rsp_valid, rsp_id, rsp_last, rsp_err, rsp_data};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int i, input logic [9:0] a, input logic [3:0] l);
      int  t;
      logic done;
      t = 0;
      done = 1'b0;
      if (i == 0) begin req_addr0 = a; req_len0 = l; v0 = 1'b1; end
      else        begin req_addr1 = a; req_len1 = l; v1 = 1'b1; end
      while (!done) begin
         @(negedge clk);
         if (req_ready[i]) done = 1'b1;
         else begin
            t++;
            if (t > 3000) begin
               fail_now(i == 0 ? "req0_accept_timeout" : "req1_accept_timeout");
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (i == 0) v0 = 1'b0; else v1 = 1'b0;
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 600 && !done; t++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
      end
      if (!done) fail_now("drain_timeout");
      chk("beats_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic to_posedge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return 10'($urandom_range(896, 1023));
      else if (r == 1) return 10'($urandom_range(888, 895));
      else             return 10'($urandom_range(0, 895));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int base;
      logic hit;
      n_total = 0; n_pass = 0; cyc = 0; n_beats = 0;
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
      req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
      rsp_ready = 1'b1; lat_chk = 1'b0; rand_on = 1'b0;
      m_ptr = 1'b0; p_valid = 1'b0; p_ready = 1'b0; busy_chk = 1'b0;
      first_pending = 1'b0; hs_cyc = 0; prev_beat_cyc = 0;

      // reset values with both requests pending
      repeat (3) @(negedge clk);
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rsp_fields", 32'({rsp_id, rsp_last, rsp_err, rsp_data}), 32'd0);
      v0 = 1'b0; v1 = 1'b0;
      rst_n = 1'b1;

      // contention after reset: req0, then req1, then req0 again
      lat_chk = 1'b1;
      to_posedge();
      fork
         send(0, 10'h020, 4'd1);
         send(1, 10'h040, 4'd2);
      join
      wait_drain();
      to_posedge();
      fork
         send(0, 10'h080, 4'd0);
         send(1, 10'h0C0, 4'd1);
      join
      wait_drain();

      // single request, len=3
      to_posedge();
      send(0, 10'h010, 4'd3);
      wait_drain();

      // wrap past the last ROM word
      to_posedge();
      send(1, 10'h37E, 4'd3);
      wait_drain();

      // out-of-range start address
      to_posedge();
      send(1, 10'h3FF, 4'd7);
      wait_drain();
      to_posedge();
      send(0, 10'h380, 4'd15);
      wait_drain();

      // backpressure mid-burst
      lat_chk = 1'b0;
      to_posedge();
      send(0, 10'h100, 4'd7);
      repeat (3) to_posedge();
      rsp_ready = 1'b0;
      repeat (5) to_posedge();
      rsp_ready = 1'b1;
      wait_drain();

      // reset during beat 2 of a len=7 burst
      to_posedge();
      base = n_beats;
      send(0, 10'h200, 4'd7);
      hit = 1'b0;
      for (int t = 0; t < 50 && !hit; t++) begin
         @(negedge clk);
         #1;
         if (n_beats >= base + 2) hit = 1'b1;
      end
      if (!hit) fail_now("beat2_wait");
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      exp_q.delete();
      req_addr0 = 10'h010; req_addr1 = 10'h020;
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("midreset_req_ready", 32'(req_ready), 32'd0);
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("after_reset_busy", 32'(busy), 32'd0);
      chk("after_reset_no_resume", 32'(rsp_valid), 32'd0);
      to_posedge();
      fork
         send(1, 10'h050, 4'd2);
         send(0, 10'h060, 4'd1);
      join
      wait_drain();

      // randomized traffic with random backpressure
      rand_on = 1'b1;
      fork
         begin
            fork
               for (int n = 0; n < 60; n++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #1;
                  send(0, rand_addr(), 4'($urandom_range(0, 15)));
               end
               for (int n = 0; n < 60; n++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #1;
                  send(1, rand_addr(), 4'($urandom_range(0, 15)));
               end
            join
            rand_on = 1'b0;
         end
         while (rand_on) begin
            to_posedge();
            rsp_ready = ($urandom_range(0, 9) < 7);
         end
      join
      rsp_ready = 1'b1;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rom_stream_arbiter.md
ROM_STREAM_ARBITER -- requirements
Module: rom_stream_arbiter

Interface
REQ-001 SHALL have parameters: DEPTH, default 896, number of valid ROM words; ADDR_W, default 10, ROM address width; DATA_W, default 8, ROM word width; LEN_W, default 4, burst-length field width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept.
- req_addr0, req_addr1  in  ADDR_W  burst start address per requester.
- req_len0, req_len1  in  LEN_W  burst length minus one per requester.
- rom_addr  out  ADDR_W  address to the combinational ROM.
- rom_data  in  DATA_W  ROM word for rom_addr, same cycle.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response sink accept.
- rsp_data  out  DATA_W  response word.
- rsp_id  out  1  requester that owns the beat.
- rsp_last  out  1  final beat of a burst.
- rsp_err  out  1  beat is an out-of-range error beat.
- busy  out  1  high in BURST state.

Function
REQ-003 SHALL implement an FSM with states IDLE and BURST.
REQ-004 In IDLE, req_ready SHALL be one-hot or zero: one valid requester gets ready; both valid -> the requester selected by the round-robin pointer; none valid -> 2'b00.
REQ-005 In BURST, req_ready SHALL be 2'b00.
REQ-006 A handshake (req_valid[i] & req_ready[i]) SHALL latch address, length and id, go to BURST, and toggle the pointer to the other requester.
REQ-007 The pointer SHALL change only on a handshake; a lone requester SHALL win regardless of pointer.
REQ-008 rom_addr SHALL equal the current beat address register; it is don't-care in IDLE.
REQ-009 One-entry output register: it loads a beat when in BURST and (rsp_valid==0 or rsp_ready==1).
REQ-010 Each load SHALL capture rom_data, id, last and err, then increment the beat address and decrement the remaining count.
REQ-011 The beat address SHALL wrap from DEPTH-1 to 0.
REQ-012 A burst SHALL deliver exactly len+1 beats; rsp_last SHALL be 1 only on the final beat.
REQ-013 The FSM SHALL return to IDLE in the cycle it loads the last beat.
REQ-014 Latency: for a handshake in cycle N, the first rsp_valid SHALL be in cycle N+1.
REQ-015 With rsp_ready held high, throughput SHALL be one beat per cycle.
REQ-016 After a burst, the next handshake SHALL occur no earlier than the cycle after the last load.
REQ-017 While rsp_valid & !rsp_ready, all rsp_* outputs SHALL hold stable.
REQ-018 rsp_valid SHALL drop after a consumed beat when no new beat loads in the same cycle.
REQ-019 Start address >= DEPTH SHALL still be accepted.
REQ-020 Such a request SHALL produce exactly one beat, regardless of len: rsp_data=0, rsp_err=1, rsp_last=1; the ROM is not read.
REQ-021 In-range bursts SHALL have rsp_err=0 on every beat.

Reset
REQ-022 On rst_n low, at any time including mid-burst, the block SHALL enter IDLE within the reset assertion.
REQ-023 Reset values: pointer=requester 0; rsp_valid, rsp_last, rsp_err, rsp_id, busy = 0; rsp_data=0; req_ready=0 while rst_n is low.
REQ-024 An in-flight burst SHALL be discarded by reset and not resumed.

Structure
REQ-025 Shared package rom_arb_pkg SHALL hold DEPTH, ADDR_W, DATA_W, LEN_W and the FSM state enum.
REQ-026 Two-way round-robin grant logic SHALL be a sub-module, rom_arb_rr2: valid[1:0], advance -> grant[1:0], with the pointer flop inside.

Verification
REQ-027 Single request: req0, addr=0x010, len=3, rsp_ready=1 -> beats rom[0x010..0x013] in cycles N+1..N+4; rsp_last on the 4th beat; rsp_id=0.
REQ-028 Simultaneous requests after reset: req0 and req1 both valid -> req0 granted first, then req1; the next contention grants req0 again.
REQ-029 Wrap: addr=0x37E (894), len=3 -> beat addresses 894, 895, 0, 1.
REQ-030 Out-of-range: addr=0x3FF, len=7 -> exactly one beat with data 0x00, rsp_err=1, rsp_last=1.
REQ-031 Backpressure: rsp_ready low for 5 cycles mid-burst -> outputs held stable, no beat lost or duplicated, order preserved.
REQ-032 Reset mid-burst: rst_n low during beat 2 of len=7 -> rsp_valid=0 immediately; after release, IDLE, busy=0, pointer=0.
